// File: rtl/cnn_pkg.sv
// Shared types for the CNN datapath: pixel type and feeder FSM states.
package cnn_pkg;

    localparam int CNN_PIX_W = 16;

    // Signed pixel word shared by the feeder and the conv layers.
    typedef logic signed [CNN_PIX_W-1:0] pixel_t;

    // Frame feeder sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feeder_state_t;

    // Number of pixels in one raster frame.
    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/pixel_skid_buf.sv
// Two-entry FIFO that absorbs RAM return data while the consumer stalls.
module pixel_skid_buf #(
    parameter int PIX_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [PIX_W-1:0] data_in,
    output logic [PIX_W-1:0] data_out,
    output logic [1:0]       count
);

    logic [PIX_W-1:0] slot [2];
    logic             wr_idx;
    logic             rd_idx;

    // Storage only; slot contents are never observed while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            slot[wr_idx] <= data_in;
        end
    end

    // Write/read pointers advance on push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
        end else begin
            if (push) begin
                wr_idx <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign data_out = slot[rd_idx];

endmodule

// File: rtl/pixel_feeder.sv
// Reads one frame from a 1-cycle-latency RAM and streams it as valid/ready.
//
//  state  | meaning
//  IDLE   | waiting for start
//  STREAM | issuing reads and handing pixels to the consumer
//  DONE   | one-cycle done pulse, frame counter bump
module pixel_feeder
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PIX_W  = CNN_PIX_W,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic signed [PIX_W-1:0] mem_rdata,
    input  logic                    ready,
    output logic signed [PIX_W-1:0] pixel_out,
    output logic                    valid_out,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             frame_cnt
);

    localparam int              N     = frame_pixels(IMG_W, IMG_H);
    localparam logic [ADDR_W:0] N_PTR = (ADDR_W+1)'(N);

    feeder_state_t    state;
    feeder_state_t    state_nxt;
    logic [ADDR_W:0]  rd_ptr;
    logic             in_flight;
    logic [1:0]       buf_count;
    logic [PIX_W-1:0] buf_data;
    logic             buf_empty;
    logic             buf_push;
    logic             buf_pop;
    logic             xfer;
    logic             last_xfer;
    logic [2:0]       pending;

    // Pixels owned by the feeder but not yet transferred: buffered plus returning.
    assign pending   = {1'b0, buf_count} + {2'b00, in_flight};
    assign buf_empty = (buf_count == 2'd0);

    // Returning RAM data bypasses an empty buffer so the first pixel shows
    // the cycle it arrives; once the buffer holds data, its head is presented.
    assign valid_out = (state == STREAM) && (pending != 3'd0);
    assign pixel_out = !valid_out ? '0 :
                       (!buf_empty ? $signed(buf_data) : mem_rdata);
    assign xfer      = valid_out && ready;

    // Data returning while the bypass is consumed never enters the buffer.
    assign buf_push  = in_flight && !(buf_empty && xfer);
    assign buf_pop   = xfer && !buf_empty;

    // A read is allowed only if its data is sure to find a free slot.
    assign mem_rd_en = (state == STREAM) && (rd_ptr < N_PTR) && (pending < 3'd2);
    assign mem_addr  = rd_ptr[ADDR_W-1:0];

    assign last_xfer = xfer && (rd_ptr == N_PTR) && (pending == 3'd1);

    assign busy = (state == STREAM);
    assign done = (state == DONE);

    pixel_skid_buf #(
        .PIX_W (PIX_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .push     (buf_push),
        .pop      (buf_pop),
        .data_in  (mem_rdata),
        .data_out (buf_data),
        .count    (buf_count)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start outside IDLE is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (last_xfer) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read pointer: cleared on accepted start, advanced per issued read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if ((state == IDLE) && start) begin
            rd_ptr <= '0;
        end else if (mem_rd_en) begin
            rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
        end
    end

    // RAM data is valid exactly one cycle after the read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight <= 1'b0;
        end else begin
            in_flight <= mem_rd_en;
        end
    end

    // Completed-frame counter, free-running wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= 16'd0;
        end else if (state == DONE) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pixel_feeder.sv
// Directed bench for pixel_feeder on a 4x4 frame with a scoreboard of pixels.
module tb_pixel_feeder;
    import cnn_pkg::*;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int N      = IMG_W * IMG_H;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    pixel_t            mem_rdata;
    logic              ready;
    pixel_t            pixel_out;
    logic              valid_out;
    logic              busy;
    logic              done;
    logic [15:0]       frame_cnt;

    pixel_t ram [N];
    pixel_t sb_q [$];
    int     errors = 0;
    int     checks = 0;
    int     xfers  = 0;
    int     exp_frames = 0;
    bit     prev_stall = 1'b0;
    pixel_t prev_pix;

    pixel_feeder #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .PIX_W  (CNN_PIX_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .ready     (ready),
        .pixel_out (pixel_out),
        .valid_out (valid_out),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle-latency synchronous RAM model.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard monitor: every transfer pops one expected pixel; stalled
    // outputs must hold until transferred.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                check("hold_valid", {31'b0, valid_out}, 32'd1);
                check("hold_pixel", pixel_out, prev_pix);
            end
            if (valid_out && ready) begin
                xfers++;
                if (sb_q.size() == 0) begin
                    check("extra_xfer", pixel_out, 32'hDEAD);
                end else begin
                    check("pixel", pixel_out, sb_q.pop_front());
                end
            end
            prev_stall = valid_out && !ready;
            prev_pix   = pixel_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Called #1 after a posedge; leaves the bench #1 into cycle 1.
    task automatic do_start();
        for (int i = 0; i < N; i++) sb_q.push_back(ram[i]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready high; mode 1: ready toggles each cycle.
    task automatic wait_done(input int max_cyc, input int mode);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            if (mode == 1) ready = ~ready;
            else ready = 1'b1;
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("done_seen", {31'b0, seen}, 32'd1);
    endtask

    task automatic end_frame(input string tag, input int xfers_before);
        exp_frames++;
        check({tag, "_xfers"}, xfers - xfers_before, N);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
        check({tag, "_frame_cnt"}, frame_cnt, exp_frames);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_en"}, {31'b0, mem_rd_en}, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_pixel"}, pixel_out, 0);
        check({tag, "_valid"}, {31'b0, valid_out}, 0);
        check({tag, "_busy"}, {31'b0, busy}, 0);
        check({tag, "_done"}, {31'b0, done}, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < N; i++) ram[i] = pixel_t'(100 + i);
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // 1) ready held high: pixels on cycles 2..17, done on 18.
        x0 = xfers;
        do_start();
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            check($sformatf("t1_valid_c%0d", k), {31'b0, valid_out}, (k >= 2 && k <= 17) ? 1 : 0);
            check($sformatf("t1_done_c%0d", k), {31'b0, done}, (k == 18) ? 1 : 0);
            if (k == 1) begin
                check("t1_rd_en_c1", {31'b0, mem_rd_en}, 1);
                check("t1_addr_c1", mem_addr, 0);
                check("t1_busy_c1", {31'b0, busy}, 1);
            end
            if (k == 2) check("t1_first_pixel", pixel_out, 100);
            if (k == 18) check("t1_busy_done", {31'b0, busy}, 0);
            @(posedge clk); #1;
        end
        end_frame("t1", x0);

        // 2) ready toggling every cycle.
        x0 = xfers;
        ready = 1'b0;
        do_start();
        wait_done(200, 1);
        end_frame("t2", x0);

        // 3) ready low through cycle 12: head held, reads stop at 2 outstanding.
        x0 = xfers;
        ready = 1'b0;
        do_start();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                check($sformatf("t3_valid_c%0d", k), {31'b0, valid_out}, 1);
                check($sformatf("t3_pixel_c%0d", k), pixel_out, 100);
            end
            if (k >= 3) check($sformatf("t3_rd_en_c%0d", k), {31'b0, mem_rd_en}, 0);
            @(posedge clk); #1;
        end
        wait_done(100, 0);
        end_frame("t3", x0);

        // 4) stray start mid-frame is ignored.
        x0 = xfers;
        ready = 1'b1;
        do_start();
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100, 0);
        end_frame("t4", x0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_idle_after", {31'b0, busy}, 0);

        // 5) reset in cycle 8 mid-frame, then a clean restart from addr 0.
        do_start();
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_zero_outputs("t5_reset");
        @(negedge clk);
        sb_q.delete();
        exp_frames = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        x0 = xfers;
        do_start();
        @(negedge clk);
        check("t5_restart_addr", mem_addr, 0);
        @(negedge clk);
        check("t5_first_pixel", pixel_out, 100);
        @(posedge clk); #1;
        wait_done(100, 0);
        end_frame("t5", x0);

        // 6) back-to-back frames with negative pixels, started right after done.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_frames = 0;
        for (int i = 0; i < N; i++) ram[i] = (i % 2 == 1) ? pixel_t'(-1) : pixel_t'(100 + i);
        @(posedge clk); #1;
        x0 = xfers;
        do_start();
        wait_done(100, 0);
        end_frame("t6a", x0);
        x0 = xfers;
        do_start();
        @(negedge clk);
        check("t6_b2b_busy", {31'b0, busy}, 1);
        @(posedge clk); #1;
        wait_done(100, 0);
        end_frame("t6b", x0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
